// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store unit: decodes the EX instruction, runs one req/ack data-bus
// transaction per aligned LOAD/STORE, stalls the pipeline meanwhile and extends load data.
module mem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_en,
  input  logic [31:0]       ex_insn,
  input  logic [ADDR_W-1:0] ex_alu_out,
  input  logic [31:0]       ex_store_data,
  input  logic              mem_flush,
  output logic              mem_stall,
  output logic [31:0]       mem_data_to_gpr,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              bus_err_q, bus_err_d;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        is_load, is_store, f3_ok, misaligned, access, start;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        unused_insn;

  assign opcode      = ex_insn[6:0];
  assign f3          = ex_insn[14:12];
  assign unused_insn = ^{ex_insn[31:15], ex_insn[11:7]};

  assign is_load    = (opcode == 7'b0000011);
  assign is_store   = (opcode == 7'b0100011);
  assign f3_ok      = is_load  ? (f3[1:0] != 2'b11) && !(f3[2] && f3[1])
                    : is_store ? (!f3[2] && f3[1:0] != 2'b11) : 1'b0;
  assign misaligned = ((f3[1:0] == 2'b01) && ex_alu_out[0]) ||
                      ((f3[1:0] == 2'b10) && (ex_alu_out[1:0] != 2'b00));
  assign access     = ex_en && !mem_flush && f3_ok;
  assign start      = access && !misaligned;

  always_comb begin
    case (f3[1:0])
      2'b00:   begin st_be = 4'b0001 << ex_alu_out[1:0];            st_wdata = {4{ex_store_data[7:0]}};  end
      2'b01:   begin st_be = ex_alu_out[1] ? 4'b1100 : 4'b0011;     st_wdata = {2{ex_store_data[15:0]}}; end
      default: begin st_be = 4'b1111;                               st_wdata = ex_store_data;            end
    endcase
  end

  // Lane selection uses the address bits latched at issue, not the live EX inputs.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    lane_d       = lane_q;
    f3_d         = f3_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    bus_err_d    = 1'b0;
    mem_stall    = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        misalign_err = reset && access && misaligned;
        if (start) begin
          mem_stall = reset;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {ex_alu_out[ADDR_W-1:2], 2'b00};
          be_d      = is_store ? st_be : 4'b1111;
          wdata_d   = is_store ? st_wdata : 32'd0;
          lane_d    = ex_alu_out[1:0];
          f3_d      = f3;
          cnt_d     = 8'd0;
          data_d    = 32'd0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          data_d  = we_q ? 32'd0 : ld_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          data_d    = 32'd0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      lane_q    <= 2'd0;
      f3_q      <= 3'd0;
      cnt_q     <= 8'd0;
      data_q    <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;
  assign bus_err         = bus_err_q;
  assign mem_data_to_gpr = (state_q == S_DONE) ? data_q : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and randomized accesses checked against an
// arithmetic model of addressing, lane enables, extension, stall length and timeout.
module tb_mem_access_ctrl;
  localparam int TO = 4;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_en;
  logic [31:0] ex_insn;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic        mem_flush;
  logic        mem_stall;
  logic [31:0] mem_data_to_gpr;
  logic        misalign_err;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ex_en(ex_en), .ex_insn(ex_insn), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .mem_flush(mem_flush), .mem_stall(mem_stall),
    .mem_data_to_gpr(mem_data_to_gpr), .misalign_err(misalign_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // One access from its IDLE cycle through DONE; optional trailing idle cycle.
  task automatic run_access(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata, input int wait_n,
                            input bit give_ack, input bit flush, input bit gap, input string tag);
    bit is_ld, is_st, f3ok, mis, go, tmo, sgn;
    int size, stall_cnt, exp_stall;
    logic [31:0] mask, exp_res, exp_wdata, exp_addr, insn;
    logic [3:0]  exp_be;
    is_ld = (opc == OP_LD);
    is_st = (opc == OP_ST);
    f3ok  = is_ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
          : is_st ? (f3 <= 3'd2) : 1'b0;
    size  = 1 << f3[1:0];
    mis   = f3ok && !flush && ((addr % size) != 0);
    go    = f3ok && !flush && !mis;
    tmo   = !give_ack || (wait_n >= TO);
    exp_stall = !go ? 0 : (tmo ? TO + 1 : wait_n + 2);
    exp_addr  = addr & 32'hFFFF_FFFC;
    mask      = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_be    = is_ld ? 4'hF : (size == 4) ? 4'hF : 4'(((size == 1) ? 1 : 3) << (addr % 4));
    exp_wdata = (size == 1) ? (sdata & 32'hFF) * 32'h0101_0101
              : (size == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
    exp_res   = (rdata >> (8 * (addr % 4))) & mask;
    sgn       = (f3[2] == 1'b0) && (size < 4);
    if (sgn && ((exp_res & ((mask >> 1) + 1)) != 0)) exp_res = exp_res | ~mask;
    if (is_st || tmo) exp_res = 32'd0;
    stall_cnt = 0;

    @(negedge clk);
    insn = $urandom;
    insn[14:12] = f3;
    insn[6:0]   = opc;
    ex_en = 1'b1; ex_insn = insn; ex_alu_out = addr; ex_store_data = sdata;
    mem_flush = flush; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #1;
    n_checks += 3;
    if (mem_stall !== go) begin n_errors++; $display("FAIL %s idle_stall act=%0b exp=%0b", tag, mem_stall, go); end
    if (misalign_err !== mis) begin n_errors++; $display("FAIL %s misalign act=%0b exp=%0b", tag, misalign_err, mis); end
    if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL %s idle_req act=%0b exp=0", tag, dmem_req); end
    stall_cnt += int'(mem_stall);

    if (go) begin
      for (int k = 0; k < TO; k++) begin
        @(negedge clk);
        ex_en = 1'($urandom); ex_insn = $urandom; ex_alu_out = $urandom; mem_flush = 1'($urandom);
        dmem_ack   = give_ack && (k == wait_n);
        dmem_rdata = (k == wait_n) ? rdata : $urandom;
        #1;
        n_checks += 6;
        if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL %s req k=%0d act=%0b exp=1", tag, k, dmem_req); end
        if (dmem_we !== is_st) begin n_errors++; $display("FAIL %s we act=%0b exp=%0b", tag, dmem_we, is_st); end
        if (dmem_addr !== exp_addr) begin n_errors++; $display("FAIL %s addr act=%h exp=%h", tag, dmem_addr, exp_addr); end
        if (dmem_be !== exp_be) begin n_errors++; $display("FAIL %s be act=%b exp=%b", tag, dmem_be, exp_be); end
        if (mem_data_to_gpr !== 32'd0) begin n_errors++; $display("FAIL %s req_data act=%h exp=0", tag, mem_data_to_gpr); end
        if (bus_err !== 1'b0) begin n_errors++; $display("FAIL %s req_buserr act=%0b exp=0", tag, bus_err); end
        if (is_st) begin
          n_checks++;
          if (dmem_wdata !== exp_wdata) begin n_errors++; $display("FAIL %s wdata act=%h exp=%h", tag, dmem_wdata, exp_wdata); end
        end
        stall_cnt += int'(mem_stall);
        if (dmem_ack) break;
      end
      @(negedge clk);
      ex_en = 1'($urandom); ex_insn = $urandom; mem_flush = 1'($urandom);
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1;
      n_checks += 4;
      if (mem_stall !== 1'b0) begin n_errors++; $display("FAIL %s done_stall act=%0b exp=0", tag, mem_stall); end
      if (mem_data_to_gpr !== exp_res) begin n_errors++; $display("FAIL %s result act=%h exp=%h", tag, mem_data_to_gpr, exp_res); end
      if (bus_err !== tmo) begin n_errors++; $display("FAIL %s bus_err act=%0b exp=%0b", tag, bus_err, tmo); end
      if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL %s done_req act=%0b exp=0", tag, dmem_req); end
    end
    n_checks++;
    if (stall_cnt !== exp_stall) begin n_errors++; $display("FAIL %s stall_cycles act=%0d exp=%0d", tag, stall_cnt, exp_stall); end

    if (gap || !go) begin
      @(negedge clk);
      ex_en = 1'b0; mem_flush = 1'b0; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1;
      n_checks += 4;
      if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL %s after_req act=%0b exp=0", tag, dmem_req); end
      if (mem_stall !== 1'b0) begin n_errors++; $display("FAIL %s after_stall act=%0b exp=0", tag, mem_stall); end
      if (bus_err !== 1'b0) begin n_errors++; $display("FAIL %s after_buserr act=%0b exp=0", tag, bus_err); end
      if (mem_data_to_gpr !== 32'd0) begin n_errors++; $display("FAIL %s after_data act=%h exp=0", tag, mem_data_to_gpr); end
    end
    $display("txn %s opc=%b f3=%0d addr=%h go=%0b mis=%0b tmo=%0b stall=%0d res=%h",
             tag, opc, f3, addr, go, mis, tmo, stall_cnt, exp_res);
  endtask

  task automatic test_reset();
    reset = 1'b0; ex_en = 1'b0; ex_insn = 32'd0; ex_alu_out = 32'd0; ex_store_data = 32'd0;
    mem_flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    n_checks += 4;
    if ({dmem_req, dmem_we, mem_stall, misalign_err, bus_err} !== 5'd0) begin
      n_errors++; $display("FAIL reset_ctrl act=%b exp=00000", {dmem_req, dmem_we, mem_stall, misalign_err, bus_err});
    end
    if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_bus addr=%h wdata=%h exp=0", dmem_addr, dmem_wdata);
    end
    if (dmem_be !== 4'd0) begin n_errors++; $display("FAIL reset_be act=%b exp=0000", dmem_be); end
    if (mem_data_to_gpr !== 32'd0) begin n_errors++; $display("FAIL reset_data act=%h exp=0", mem_data_to_gpr); end
    @(negedge clk);
    reset = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_directed();
    run_access(OP_LD, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b1, "lw_100");
    run_access(OP_LD, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, 1'b0, 1'b1, "lb_103");
    run_access(OP_LD, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b1, 1'b0, 1'b1, "lbu_103");
    run_access(OP_LD, 3'd5, 32'h102, 32'h0, 32'h80FF0000, 2, 1'b1, 1'b0, 1'b1, "lhu_102");
    run_access(OP_ST, 3'd1, 32'h206, 32'h1234ABCD, 32'h0, 3, 1'b1, 1'b0, 1'b1, "sh_206");
    run_access(OP_LD, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1, "lw_mis");
    run_access(OP_LD, 3'd2, 32'h180, 32'h0, 32'h12345678, 0, 1'b0, 1'b0, 1'b1, "lw_timeout");
  endtask

  task automatic test_no_access();
    run_access(7'b0110011, 3'd2, 32'h100, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1, "alu_op");
    run_access(OP_LD, 3'd3, 32'h104, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1, "ld_f3_011");
    run_access(OP_ST, 3'd4, 32'h104, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1, "st_f3_100");
    run_access(OP_LD, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b1, 1'b1, 1'b1, "flush_mis");
    run_access(OP_ST, 3'd2, 32'h108, 32'h55, 32'h0, 0, 1'b1, 1'b1, 1'b1, "flush_sw");
  endtask

  task automatic test_back_to_back();
    run_access(OP_ST, 3'd0, 32'h301, 32'hA5A5_5A3C, 32'h0, 0, 1'b1, 1'b0, 1'b0, "b2b_sb");
    run_access(OP_LD, 3'd1, 32'h302, 32'h0, 32'h8001_7FFF, 0, 1'b1, 1'b0, 1'b0, "b2b_lh");
    run_access(OP_ST, 3'd2, 32'h304, 32'hCAFE_F00D, 32'h0, 1, 1'b1, 1'b0, 1'b1, "b2b_sw");
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    ex_en = 1'b1; ex_insn = {17'd0, 3'd2, 5'd1, OP_LD}; ex_alu_out = 32'h300; mem_flush = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    ex_en = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL rst_mid pre_req act=%0b exp=1", dmem_req); end
    #2 reset = 1'b0;
    #1;
    n_checks += 2;
    if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL rst_mid req act=%0b exp=0", dmem_req); end
    if (mem_stall !== 1'b0) begin n_errors++; $display("FAIL rst_mid stall act=%0b exp=0", mem_stall); end
    @(negedge clk);
    reset = 1'b1;
    $display("txn reset mid-REQ");
    run_access(OP_LD, 3'd2, 32'h300, 32'h0, 32'h0BAD_CAFE, 0, 1'b1, 1'b0, 1'b1, "lw_after_rst");
  endtask

  task automatic test_random();
    logic [6:0] opc;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       opc = 7'($urandom);
        1, 2, 3, 4: opc = OP_ST;
        default: opc = OP_LD;
      endcase
      run_access(opc, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), 1'($urandom), "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_no_access();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
